// File: rtl/pixel_pair_packer.sv
// Packs a single-pixel RGB valid/ready stream into two-pixel-per-clock raster pairs
// with frame sync, start-up delay and programmable line blanking.
module pixel_pair_packer #(
  parameter int WIDTH         = 768,
  parameter int HEIGHT        = 512,
  parameter int START_DELAY   = 100,
  parameter int HBLANK_CYCLES = 160
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        START,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [23:0] IN_DATA,
  output logic        VSYNC,
  output logic        HSYNC,
  output logic [7:0]  DATA_R0,
  output logic [7:0]  DATA_G0,
  output logic [7:0]  DATA_B0,
  output logic [7:0]  DATA_R1,
  output logic [7:0]  DATA_G1,
  output logic [7:0]  DATA_B1,
  output logic        FRAME_DONE
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DELAY  = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_HBLANK = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [15:0] COL_LAST = 16'(WIDTH - 2);
  localparam logic [15:0] ROW_LAST = 16'(HEIGHT - 1);
  localparam logic [15:0] DLY_LAST = 16'(START_DELAY - 1);
  localparam logic [15:0] HBL_LAST = (HBLANK_CYCLES > 0) ? 16'(HBLANK_CYCLES - 1) : 16'd0;
  localparam bit          HBL_EN   = (HBLANK_CYCLES > 0);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] col_q, col_d;
  logic [15:0] row_q, row_d;
  logic        phase_q, phase_d;
  logic [23:0] hold_q, hold_d;
  logic [23:0] pix0_q, pix0_d;
  logic [23:0] pix1_q, pix1_d;
  logic        hsync_q, hsync_d;
  logic        accept_s;

  assign accept_s = IN_VALID && (state_q == ST_ACTIVE);

  // Next-state, counter and pair-assembly logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    phase_d = phase_q;
    hold_d  = hold_q;
    pix0_d  = pix0_q;
    pix1_d  = pix1_q;
    hsync_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_DELAY;
          cnt_d   = 16'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DELAY: begin
        if (cnt_q == DLY_LAST) begin
          state_d = ST_ACTIVE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_ACTIVE: begin
        if (accept_s) begin
          if (!phase_q) begin
            hold_d  = IN_DATA;
            phase_d = 1'b1;
          end else begin
            pix0_d  = hold_q;
            pix1_d  = IN_DATA;
            hsync_d = 1'b1;
            phase_d = 1'b0;
            if (col_q == COL_LAST) begin
              col_d = 16'd0;
              cnt_d = 16'd0;
              // Row is rewound at frame end so the next START begins on line 0.
              if (row_q == ROW_LAST) begin
                row_d   = 16'd0;
                state_d = ST_DONE;
              end else begin
                row_d = row_q + 16'd1;
                if (HBL_EN) begin
                  state_d = ST_HBLANK;
                end else begin
                  state_d = ST_ACTIVE;
                end
              end
            end else begin
              col_d = col_q + 16'd2;
            end
          end
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_HBLANK: begin
        if (cnt_q == HBL_LAST) begin
          state_d = ST_ACTIVE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and output pair registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      col_q   <= 16'd0;
      row_q   <= 16'd0;
      phase_q <= 1'b0;
      hold_q  <= 24'd0;
      pix0_q  <= 24'd0;
      pix1_q  <= 24'd0;
      hsync_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      phase_q <= phase_d;
      hold_q  <= hold_d;
      pix0_q  <= pix0_d;
      pix1_q  <= pix1_d;
      hsync_q <= hsync_d;
    end
  end

  assign IN_READY   = (state_q == ST_ACTIVE);
  assign VSYNC      = (state_q == ST_DELAY) || (state_q == ST_ACTIVE) || (state_q == ST_HBLANK);
  assign FRAME_DONE = (state_q == ST_DONE);
  assign HSYNC      = hsync_q;
  assign DATA_R0    = pix0_q[23:16];
  assign DATA_G0    = pix0_q[15:8];
  assign DATA_B0    = pix0_q[7:0];
  assign DATA_R1    = pix1_q[23:16];
  assign DATA_G1    = pix1_q[15:8];
  assign DATA_B1    = pix1_q[7:0];

endmodule

// File: doc/pixel_pair_packer.md
# pixel_pair_packer

Upstream stage of `display_model`. Accepts a single-pixel 24-bit RGB stream over a valid/ready handshake, packs consecutive pixels into pairs, and emits them as the two-pixel-per-clock raster that `display_model` consumes. The raster carries `VSYNC` for the frame window, an `HSYNC` strobe per pair, and programmable start-up delay and line blanking. `FRAME_DONE` marks the end of each frame.

## Interface
- `WIDTH`, default 768: pixels per line; must be even and ≥2.
- `HEIGHT`, default 512: lines per frame; ≥1.
- `START_DELAY`, default 100: cycles between frame start and the first accepted pixel; ≥1.
- `HBLANK_CYCLES`, default 160: blanking cycles between lines; 0 means no blanking.

All four parameters must be ≤ 65535. Counters are 16 bits.

Ports:
- `HCLK` input, 1: clock, rising edge.
- `HRESETn` input, 1: reset, asynchronous, active-low.
- `START` input, 1: one-cycle pulse that starts a frame. Sampled only in IDLE.
- `IN_VALID` input, 1: input pixel valid.
- `IN_READY` output, 1: block can accept a pixel.
- `IN_DATA` input, 24: pixel, {R[23:16], G[15:8], B[7:0]}.
- `VSYNC` output, 1: high while a frame is in progress.
- `HSYNC` output, 1: one-cycle strobe; the DATA_* outputs hold a valid pair.
- `DATA_R0`, `DATA_G0`, `DATA_B0` output, 8 each: first (earlier) pixel of the pair.
- `DATA_R1`, `DATA_G1`, `DATA_B1` output, 8 each: second pixel of the pair.
- `FRAME_DONE` output, 1: one-cycle pulse at end of frame.

## Operation
States: IDLE, DELAY, ACTIVE, HBLANK, DONE.

**IDLE**
- `IN_READY`=0, `VSYNC`=0.
- `START`=1 → DELAY, with the delay counter cleared.

**DELAY**
- `VSYNC`=1, `IN_READY`=0.
- Runs for exactly `START_DELAY` cycles, then → ACTIVE.

**ACTIVE**
- `IN_READY`=1, decoded from the state register.
- A pixel is accepted when `IN_VALID` & `IN_READY` at a rising edge.
- Phase 0 accept: store the pixel in the hold register; phase ← 1.
- Phase 1 accept:
  - register the hold pixel into the *0 outputs and the current pixel into the *1 outputs;
  - pulse `HSYNC`; phase ← 0; column += 2.
- A pair with column = `WIDTH`-2 completes the line. Then column ← 0, and:
  - if row = `HEIGHT`-1 → DONE;
  - else row += 1, then → HBLANK, or → ACTIVE directly if `HBLANK_CYCLES`=0.
- `IN_VALID` gaps are legal. A gap leaves phase, hold register and counters unchanged.

**HBLANK**
- `IN_READY`=0, `VSYNC`=1.
- Lasts exactly `HBLANK_CYCLES` cycles, then → ACTIVE.

**DONE**
- One cycle: `FRAME_DONE`=1, `VSYNC`=0, `IN_READY`=0. Then → IDLE.

**Other rules**
- `START` outside IDLE is ignored. This includes DONE and the cycle in which `START` would coincide with the transition to IDLE.
- DATA_* outputs hold their last pair while `HSYNC`=0.
- No output backpressure: the downstream block is always ready.

## Timing
- **Reset:** asynchronous assertion. Immediately: state = IDLE, phase = 0, row = 0, column = 0, hold register = 0.
- **Output reset values:** all outputs 0, namely `IN_READY`, `VSYNC`, `HSYNC`, all DATA_*, and `FRAME_DONE`.
- **Reset mid-frame:** the frame is abandoned and no `FRAME_DONE` is produced. The next `START` begins a clean frame.
- **Frame start:** `START` sampled at edge S gives `VSYNC`=1 from cycle S+1 and `IN_READY`=1 from cycle S+1+`START_DELAY`.
- **Pair latency:** second pixel accepted at edge N gives `HSYNC`=1 and the new DATA_* during cycle N+1 only.
- **Line end:** last pair of a non-final line accepted at edge N gives `IN_READY`=0 for cycles N+1 through N+`HBLANK_CYCLES`, and `IN_READY`=1 again at cycle N+1+`HBLANK_CYCLES`.
- **Frame end:** last pair of the frame accepted at edge N:
  - cycle N+1: `HSYNC`=1 and `FRAME_DONE`=1 together, `VSYNC`=0;
  - cycle N+2: IDLE.
- **Pair count:** exactly `WIDTH`·`HEIGHT`/2 `HSYNC` pulses per frame.
- **Pixel count:** exactly `WIDTH`·`HEIGHT` accepts per frame.

## Test plan
Parameters for all scenarios: `WIDTH`=4, `HEIGHT`=2, `START_DELAY`=3, `HBLANK_CYCLES`=2. Input pixels are 0x000001, 0x000002, … in order.

- **Reset:** hold `HRESETn`=0 for 25 ns with `IN_VALID`=1 → all outputs 0; `START` while in reset has no effect.
- **Continuous frame** (`START` pulse, `IN_VALID`=1 throughout):
  - `IN_READY` rises 4 cycles after the `START` edge;
  - four `HSYNC` pulses, pixel pairs (1,2), (3,4), (5,6), (7,8); first pulse has B0=0x01, B1=0x02, R/G=0;
  - `FRAME_DONE` coincides with the 4th `HSYNC`;
  - exactly 8 accepts.
- **Gapped input** (`IN_VALID` toggling every cycle) → same four pairs in order; each `HSYNC` follows its second accept by one cycle; no pixel dropped or duplicated.
- **Line blanking** → after pair (3,4), `IN_READY`=0 for exactly 2 cycles, then pair (5,6) starts; `VSYNC` stays 1 across the blank.
- **`START` handling:**
  - `START` pulsed during DELAY, ACTIVE and DONE → ignored; exactly one `FRAME_DONE`;
  - `START` in IDLE afterwards → second full frame, identical sequence.
- **Mid-line reset:** `HRESETn` low after pixel 3 is accepted → outputs 0 asynchronously. After release and `START`, pixels 0x0A and 0x0B form the first pair (B0=0x0A, B1=0x0B); no stale phase.
